// File: rtl/inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_queue
// Brief    : Circular FIFO decoupling fetch from decode, with branch predecode.
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_queue #(
    parameter int BUS_WD = 109,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    fs_to_ds_valid,
    input  logic [BUS_WD-1:0]       fs_to_ds_bus,
    output logic                    ib_allowin,
    input  logic                    ds_allowin,
    output logic                    ib_to_ds_valid,
    output logic [BUS_WD-1:0]       ib_to_ds_bus,
    output logic                    ib_is_br,
    input  logic                    flush,
    output logic [$clog2(DEPTH):0]  ib_count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    localparam logic [5:0] c_BR_OP_LO = 6'b010011;
    localparam logic [5:0] c_BR_OP_HI = 6'b011011;

    // Entry layout: {is_br, bundle}
    logic [BUS_WD:0]     r_mem [DEPTH];
    logic [PTR_W-1:0]    r_head;
    logic [PTR_W-1:0]    r_tail;

    logic                w_empty;
    logic                w_full;
    logic                w_enq;
    logic                w_deq;
    logic [5:0]          w_opcode;
    logic                w_excp;
    logic                w_is_br;
    logic [BUS_WD:0]     w_head_entry;

    assign w_empty = (r_head == r_tail);
    assign w_full  = (r_head[IDX_W-1:0] == r_tail[IDX_W-1:0]) &&
                     (r_head[IDX_W] != r_tail[IDX_W]);

    // Gated by resetn so fetch sees no room while reset is held
    assign ib_allowin     = resetn && !w_full && !flush;
    assign ib_to_ds_valid = !w_empty && !flush;

    assign w_enq = fs_to_ds_valid && ib_allowin;
    assign w_deq = ib_to_ds_valid && ds_allowin;

    assign w_opcode = fs_to_ds_bus[63:58];
    assign w_excp   = fs_to_ds_bus[68];
    assign w_is_br  = (w_opcode >= c_BR_OP_LO) && (w_opcode <= c_BR_OP_HI) && !w_excp;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_head <= '0;
            r_tail <= '0;
        end else if (flush) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_deq) begin
                r_head <= r_head + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_tail[IDX_W-1:0]] <= {w_is_br, fs_to_ds_bus};
        end
    end

    assign w_head_entry = r_mem[r_head[IDX_W-1:0]];
    assign ib_to_ds_bus = w_head_entry[BUS_WD-1:0];
    assign ib_is_br     = w_head_entry[BUS_WD];
    assign ib_count     = r_tail - r_head;

    a_no_enq_when_full : assert property (@(posedge clk) disable iff (!resetn)
        !(w_enq && w_full));
    a_no_deq_when_empty : assert property (@(posedge clk) disable iff (!resetn)
        !(w_deq && w_empty));

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch_queue
// Brief    : Self-checking bench for inst_fetch_queue against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_queue;

    localparam int BUS_WD = 109;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              resetn;
    logic              fs_to_ds_valid;
    logic [BUS_WD-1:0] fs_to_ds_bus;
    logic              ib_allowin;
    logic              ds_allowin;
    logic              ib_to_ds_valid;
    logic [BUS_WD-1:0] ib_to_ds_bus;
    logic              ib_is_br;
    logic              flush;
    logic [2:0]        ib_count;

    int tests_run;
    int tests_failed;

    // Model entry: {is_br, bundle}
    logic [BUS_WD:0] model_q [$];

    inst_fetch_queue #(.BUS_WD(BUS_WD), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .fs_to_ds_valid (fs_to_ds_valid),
        .fs_to_ds_bus   (fs_to_ds_bus),
        .ib_allowin     (ib_allowin),
        .ds_allowin     (ds_allowin),
        .ib_to_ds_valid (ib_to_ds_valid),
        .ib_to_ds_bus   (ib_to_ds_bus),
        .ib_is_br       (ib_is_br),
        .flush          (flush),
        .ib_count       (ib_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // jirl, b, bl, beq, bne, blt, bge, bltu, bgeu
    function automatic logic ref_is_br(input logic [BUS_WD-1:0] b);
        logic [5:0] op;
        op = b[63:58];
        if (b[68]) return 1'b0;
        return op inside {6'h13, 6'h14, 6'h15, 6'h16, 6'h17, 6'h18, 6'h19, 6'h1a, 6'h1b};
    endfunction

    function automatic logic [BUS_WD-1:0] mk(input logic [31:0] pc, input logic [31:0] inst,
                                            input logic excp);
        logic [31:0] ret_pc;
        logic [4:0]  idx;
        logic [3:0]  ecode;
        logic [2:0]  misc;
        ret_pc = $urandom;
        idx    = 5'($urandom);
        ecode  = 4'($urandom);
        misc   = 3'($urandom);
        return {ret_pc, idx, misc, excp, ecode, inst, pc};
    endfunction

    // One cycle: drive after negedge, check model, advance model at posedge.
    task automatic step(input string tag, input logic v, input logic [BUS_WD-1:0] bus,
                        input logic ds, input logic fl);
        logic            exp_valid;
        logic            exp_allow;
        logic [BUS_WD:0] head;
        fs_to_ds_valid = v;
        fs_to_ds_bus   = bus;
        ds_allowin     = ds;
        flush          = fl;
        #1;
        exp_valid = !fl && (model_q.size() > 0);
        exp_allow = !fl && (model_q.size() < DEPTH);
        chk({tag, ".valid"}, 128'(ib_to_ds_valid), 128'(exp_valid));
        chk({tag, ".allowin"}, 128'(ib_allowin), 128'(exp_allow));
        chk({tag, ".count"}, 128'(ib_count), 128'(model_q.size()));
        if (exp_valid) begin
            head = model_q[0];
            chk({tag, ".bus"}, 128'(ib_to_ds_bus), 128'(head[BUS_WD-1:0]));
            chk({tag, ".is_br"}, 128'(ib_is_br), 128'(head[BUS_WD]));
        end
        @(posedge clk);
        if (fl) begin
            model_q.delete();
        end else begin
            if (exp_valid && ds) void'(model_q.pop_front());
            if (v && exp_allow) model_q.push_back({ref_is_br(bus), bus});
        end
        @(negedge clk);
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        resetn         = 1'b0;
        fs_to_ds_valid = 1'b0;
        fs_to_ds_bus   = '0;
        ds_allowin     = 1'b0;
        flush          = 1'b0;

        // Reset state
        @(negedge clk);
        #1;
        chk("reset.valid", 128'(ib_to_ds_valid), 128'(0));
        chk("reset.allowin", 128'(ib_allowin), 128'(0));
        chk("reset.count", 128'(ib_count), 128'(0));
        @(negedge clk);
        #2 resetn = 1'b1;
        @(negedge clk);

        // Fill while stalled, fifth push refused
        for (int i = 0; i < 5; i++)
            step("fill", 1'b1, mk(32'h1c000000 + 32'(4*i), 32'h02800000, 1'b0), 1'b0, 1'b0);
        step("full", 1'b0, '0, 1'b0, 1'b0);

        // Drain in order
        for (int i = 0; i < 5; i++)
            step("drain", 1'b0, '0, 1'b1, 1'b0);

        // Streaming
        for (int i = 0; i < 20; i++)
            step("stream", 1'b1, mk(32'h1c001000 + 32'(4*i), $urandom, 1'b0), 1'b1, 1'b0);
        step("stream_end", 1'b0, '0, 1'b1, 1'b0);

        // Flush with a concurrent push
        for (int i = 0; i < 3; i++)
            step("preflush", 1'b1, mk(32'h1c000020 + 32'(4*i), 32'h0, 1'b0), 1'b0, 1'b0);
        step("flush", 1'b1, mk(32'h1c000100, 32'h0, 1'b0), 1'b1, 1'b1);
        step("postflush", 1'b1, mk(32'h1c000200, 32'h0, 1'b0), 1'b0, 1'b0);
        chk("postflush.pc", 128'(ib_to_ds_bus[31:0]), 128'(32'h1c000200));
        step("postflush_drain", 1'b0, '0, 1'b1, 1'b0);

        // Predecode: beq, addi.w, b with exception
        step("pre_beq", 1'b1, mk(32'h1c000300, 32'h58000000, 1'b0), 1'b0, 1'b0);
        step("pre_addi", 1'b1, mk(32'h1c000304, 32'h02800000, 1'b0), 1'b0, 1'b0);
        step("pre_bexc", 1'b1, mk(32'h1c000308, 32'h50000000, 1'b1), 1'b0, 1'b0);
        #1 chk("pre_beq.is_br", 128'(ib_is_br), 128'(1));
        step("pre_d0", 1'b0, '0, 1'b1, 1'b0);
        #1 chk("pre_addi.is_br", 128'(ib_is_br), 128'(0));
        step("pre_d1", 1'b0, '0, 1'b1, 1'b0);
        #1 chk("pre_bexc.is_br", 128'(ib_is_br), 128'(0));
        step("pre_d2", 1'b0, '0, 1'b1, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            logic [31:0] inst;
            inst = {6'($urandom_range(16, 30)), 26'($urandom)};
            step("rand", 1'($urandom_range(0, 3) != 0),
                 mk($urandom, inst, 1'($urandom_range(0, 7) == 0)),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
        end
        step("rand_flush", 1'b0, '0, 1'b0, 1'b1);

        // Async reset mid-cycle with two entries queued
        step("ar_push0", 1'b1, mk(32'h1c000400, 32'h0, 1'b0), 1'b0, 1'b0);
        step("ar_push1", 1'b1, mk(32'h1c000404, 32'h0, 1'b0), 1'b0, 1'b0);
        fs_to_ds_valid = 1'b0;
        #2 resetn = 1'b0;
        #1;
        chk("areset.valid", 128'(ib_to_ds_valid), 128'(0));
        chk("areset.allowin", 128'(ib_allowin), 128'(0));
        chk("areset.count", 128'(ib_count), 128'(0));
        model_q.delete();
        @(posedge clk);
        @(negedge clk);
        #2 resetn = 1'b1;
        step("ar_first", 1'b1, mk(32'h1c000500, 32'h0, 1'b0), 1'b0, 1'b0);
        step("ar_check", 1'b0, '0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
